encoder_fixed_point_seq: RTL and testbench
==========================================

Name: encoder_fixed_point_seq

Overview:
- Sequential dense-layer encoder: maps an N_INPUT-element fixed-point feature vector to M_OUTPUT latent values, out[j] = sum_i x[i]*w[j][i] + b[j].
- Mirror of the combinational latent-to-feature decoder; sits in front of it in the autoencoder datapath.
- Uses a single shared multiply-accumulate unit iterated by an FSM, trading latency for area.
- Valid/ready handshake on both input and output sides.

Parameters:
- N_INPUT, 9, number of input features.
- M_OUTPUT, 2, number of latent outputs.
- BITSIZE, 32, word width; signed two's complement Q16.16 (1.0 = 0x00010000).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  x/w/b valid.
- in_ready  output  1  block can accept a new job.
- x  input  N_INPUT*BITSIZE  features; element i at bits [(i+1)*BITSIZE-1 : i*BITSIZE].
- w  input  N_INPUT*M_OUTPUT*BITSIZE  weights; w[j][i] at word index j*N_INPUT+i.
- b  input  M_OUTPUT*BITSIZE  bias; b[j] at word index j.
- out_valid  output  1  out holds a finished result.
- out_ready  input  1  downstream accepts the result.
- out  output  M_OUTPUT*BITSIZE  latent vector; out[j] at word index j.
- busy  output  1  high in MAC or BIAS state.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, busy=0, out=0. Accumulator, indices i/j and captured operands all cleared.
- Reset asserted mid-job aborts the job with no output; after release the block is in IDLE.
- States:
  - IDLE: in_ready=1. in_valid&&in_ready at an edge captures x, w, b into internal registers; i=0, j=0, acc=0; go to MAC. Inputs may change freely after capture.
  - MAC: one product per cycle, acc <= acc + mul(x[i], w[j][i]); i increments. When i==N_INPUT-1, go to BIAS.
  - BIAS: out[j] <= acc + b[j]; acc <= 0; i <= 0. If j==M_OUTPUT-1 go to DONE, else j++ and go to MAC.
  - DONE: out_valid=1; out stable. out_valid&&out_ready at an edge returns to IDLE with out_valid=0; out keeps its last value.
- in_ready=0 in MAC, BIAS and DONE; no overlap of jobs. A new job may be accepted only in the cycle after the DONE handshake, when the block is back in IDLE.
- Latency: out_valid rises exactly M_OUTPUT*(N_INPUT+1) cycles after the accepting edge (20 cycles with default parameters). out_valid is held indefinitely while out_ready=0.
- Arithmetic:
  - mul(a,b) = the 64-bit signed product arithmetic-shifted right by 16, keeping the low 32 bits (truncation toward minus infinity).
  - Additions are 32-bit wrap-around; no saturation.
  - Accumulation order is i=0..N_INPUT-1, then the bias is added.
- Outputs are registered; no combinational path from inputs to out or out_valid.
- out_ready is ignored outside DONE; in_valid is ignored outside IDLE.

Test Plan:
- All x=0x00010000, all w=0x00008000, b=0 -> after exactly 20 cycles out_valid=1, out[0]=out[1]=0x00048000 (4.5).
- x[0]=0xFFFE0000 (-2.0), w[0][0]=0x00018000 (1.5), other x/w=0, b[0]=0x00004000, b[1]=0 -> out[0]=0xFFFD4000 (-2.75), out[1]=0x00000000.
- out_ready held 0 for 10 cycles after DONE -> out_valid and out stable throughout; in_ready=0 throughout; in_valid pulses in this window are ignored; out_ready=1 -> next cycle in_ready=1, out_valid=0.
- Back-to-back jobs with in_valid held high and out_ready=1 -> second job accepted on the first IDLE cycle after the DONE handshake; second result correct and unaffected by job 1 (acc cleared).
- rst_n pulsed low at cycle 7 of a job -> outputs immediately at reset values; after release, new job x=1.0, w=1.0, b=0 -> out=0x00090000 each.
- Wrap-around: x[0]=w[0][0]=0x7FFF0000, others 0 -> out[0]=0x00010000 (low 32 bits of the shifted product; no saturation).

Source files
------------

// File: rtl/encoder_fixed_point_seq_if.sv
// Job/result handshake bundle for the sequential fixed-point encoder.
// The slave side is the encoder and the master side is the job source/result sink.
interface encoder_fixed_point_seq_if #(
  parameter int N_INPUT  = 9,
  parameter int M_OUTPUT = 2,
  parameter int BITSIZE  = 32
);
  logic                                  in_valid;
  logic                                  in_ready;
  logic [N_INPUT*BITSIZE-1:0]            x;
  logic [N_INPUT*M_OUTPUT*BITSIZE-1:0]   w;
  logic [M_OUTPUT*BITSIZE-1:0]           b;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [M_OUTPUT*BITSIZE-1:0]           out;
  logic                                  busy;

  modport slave (
    input  in_valid, x, w, b, out_ready,
    output in_ready, out_valid, out, busy
  );

  modport master (
    output in_valid, x, w, b, out_ready,
    input  in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/encoder_fixed_point_seq.sv
// Dense-layer encoder out[j] = sum_i x[i]*w[j][i] + b[j] in Q16.16, one shared MAC per cycle.
// Latency M_OUTPUT*(N_INPUT+1) cycles from accept; one job at a time, result held while out_ready=0.
module encoder_fixed_point_seq #(
  parameter int N_INPUT  = 9,
  parameter int M_OUTPUT = 2,
  parameter int BITSIZE  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  encoder_fixed_point_seq_if.slave bus
);
  localparam int FRAC = 16;
  localparam int IW   = (N_INPUT  > 1) ? $clog2(N_INPUT)  : 1;
  localparam int JW   = (M_OUTPUT > 1) ? $clog2(M_OUTPUT) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(N_INPUT - 1);
  localparam logic [JW-1:0] J_LAST = JW'(M_OUTPUT - 1);

  typedef enum logic [1:0] {IDLE, MAC, BIAS, DONE} state_t;

  state_t state, state_nx;

  logic [BITSIZE-1:0] x_r   [N_INPUT];
  logic [BITSIZE-1:0] w_r   [M_OUTPUT][N_INPUT];
  logic [BITSIZE-1:0] b_r   [M_OUTPUT];
  logic [BITSIZE-1:0] out_r [M_OUTPUT];
  logic [BITSIZE-1:0] acc;
  logic [IW-1:0]      i_idx;
  logic [JW-1:0]      j_idx;

  logic                        in_ready_c;
  logic                        out_valid_c;
  logic                        busy_c;
  logic                        accept;
  logic signed [2*BITSIZE-1:0] prod;
  logic [BITSIZE-1:0]          mac_term;
  logic [M_OUTPUT*BITSIZE-1:0] out_flat;

  assign accept = bus.in_valid && in_ready_c;

  // Full-width signed product, arithmetic shift drops the extra fraction bits (floor).
  assign prod     = $signed(x_r[i_idx]) * $signed(w_r[j_idx][i_idx]);
  assign mac_term = BITSIZE'(prod >>> FRAC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = MAC;
      MAC:  if (i_idx == I_LAST) state_nx = BIAS;
      BIAS: state_nx = (j_idx == J_LAST) ? DONE : MAC;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    case (state)
      IDLE:     in_ready_c  = 1'b1;
      MAC:      busy_c      = 1'b1;
      BIAS:     busy_c      = 1'b1;
      DONE:     out_valid_c = 1'b1;
      default:  in_ready_c  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      i_idx <= '0;
      j_idx <= '0;
      for (int k = 0; k < N_INPUT; k++) x_r[k] <= '0;
      for (int jj = 0; jj < M_OUTPUT; jj++) begin
        b_r[jj]   <= '0;
        out_r[jj] <= '0;
        for (int ii = 0; ii < N_INPUT; ii++) w_r[jj][ii] <= '0;
      end
    end else begin
      case (state)
        IDLE: if (accept) begin
          acc   <= '0;
          i_idx <= '0;
          j_idx <= '0;
          for (int k = 0; k < N_INPUT; k++) x_r[k] <= bus.x[k*BITSIZE +: BITSIZE];
          for (int jj = 0; jj < M_OUTPUT; jj++) begin
            b_r[jj] <= bus.b[jj*BITSIZE +: BITSIZE];
            for (int ii = 0; ii < N_INPUT; ii++)
              w_r[jj][ii] <= bus.w[(jj*N_INPUT + ii)*BITSIZE +: BITSIZE];
          end
        end
        MAC: begin
          acc <= acc + mac_term;
          if (i_idx != I_LAST) i_idx <= i_idx + IW'(1);
        end
        BIAS: begin
          out_r[j_idx] <= acc + b_r[j_idx];
          acc          <= '0;
          i_idx        <= '0;
          if (j_idx != J_LAST) j_idx <= j_idx + JW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    out_flat = '0;
    for (int jj = 0; jj < M_OUTPUT; jj++) out_flat[jj*BITSIZE +: BITSIZE] = out_r[jj];
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.out       = out_flat;
endmodule

// File: tb/tb_encoder_fixed_point_seq.sv
// Bench for encoder_fixed_point_seq: vector table plus backpressure, back-to-back and reset sequences.
// A scoreboard queue receives expected results on accept and is checked on each result handshake.
module tb_encoder_fixed_point_seq;
  localparam int N = 9;
  localparam int M = 2;
  localparam int B = 32;
  localparam int NVEC = 6;

  typedef struct {
    logic [N*B-1:0]   x;
    logic [N*M*B-1:0] w;
    logic [M*B-1:0]   b;
    logic [M*B-1:0]   exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  encoder_fixed_point_seq_if #(.N_INPUT(N), .M_OUTPUT(M), .BITSIZE(B)) bus();

  encoder_fixed_point_seq #(.N_INPUT(N), .M_OUTPUT(M), .BITSIZE(B)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int accept_cyc = 0;
  bit in_flight  = 1'b0;
  logic [M*B-1:0] sb_q[$];
  logic [M*B-1:0] cur_exp;
  vec_t tbl[NVEC];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [M*B-1:0] act, input logic [M*B-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic logic [M*B-1:0] model(input logic [N*B-1:0] x, input logic [N*M*B-1:0] w,
                                           input logic [M*B-1:0] b);
    logic [M*B-1:0] r;
    logic [B-1:0] acc;
    logic signed [2*B-1:0] p;
    r = '0;
    for (int j = 0; j < M; j++) begin
      acc = '0;
      for (int i = 0; i < N; i++) begin
        p   = $signed(x[i*B +: B]) * $signed(w[(j*N+i)*B +: B]);
        acc = acc + 32'(p >>> 16);
      end
      r[j*B +: B] = acc + b[j*B +: B];
    end
    return r;
  endfunction

  // Monitor sits on the falling edge, where driven inputs and DUT outputs are both settled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) begin
        sb_q.push_back(cur_exp);
        accept_cyc = cyc;
        in_flight  = 1'b1;
      end
      if (bus.out_valid && in_flight) begin
        chk("latency", (M*B)'(cyc - accept_cyc - 1), (M*B)'(M*(N+1)));
        in_flight = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() > 0) chk("sb_out", bus.out, sb_q.pop_front());
        else fail_now("sb_unexpected_result");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.in_ready && n < 200) begin tick(); n++; end
    if (!bus.in_ready) fail_now(name);
  endtask

  task automatic wait_out(input string name);
    int n = 0;
    while (!bus.out_valid && n < 100) begin tick(); n++; end
    if (!bus.out_valid) fail_now(name);
  endtask

  task automatic drive(input vec_t v);
    bus.x   = v.x;
    bus.w   = v.w;
    bus.b   = v.b;
    cur_exp = v.exp;
  endtask

  task automatic scramble();
    for (int i = 0; i < N; i++) bus.x[i*B +: B] = $urandom();
    for (int i = 0; i < N*M; i++) bus.w[i*B +: B] = $urandom();
    for (int i = 0; i < M; i++) bus.b[i*B +: B] = $urandom();
  endtask

  // Single-cycle in_valid pulse; inputs are scrambled right after capture.
  task automatic start_job(input vec_t v);
    drive(v);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    scramble();
  endtask

  task automatic run_job(input vec_t v, input string name);
    wait_ready({name, "_ready"});
    start_job(v);
    chk({name, "_busy"}, (M*B)'(bus.busy), 1);
    chk({name, "_in_ready_low"}, (M*B)'(bus.in_ready), 0);
    wait_out({name, "_out_valid"});
    chk({name, "_out"}, bus.out, v.exp);
    tick();
    chk({name, "_idle_in_ready"}, (M*B)'(bus.in_ready), 1);
    chk({name, "_idle_out_valid"}, (M*B)'(bus.out_valid), 0);
    chk({name, "_out_kept"}, bus.out, v.exp);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int t = 0; t < NVEC; t++) begin
      tbl[t].x = '0; tbl[t].w = '0; tbl[t].b = '0; tbl[t].exp = '0;
    end
    // 1.0 * 0.5 summed nine times -> 4.5
    for (int i = 0; i < N; i++)   tbl[0].x[i*B +: B] = 32'h0001_0000;
    for (int i = 0; i < N*M; i++) tbl[0].w[i*B +: B] = 32'h0000_8000;
    tbl[0].exp = {32'h0004_8000, 32'h0004_8000};
    // -2.0 * 1.5 + 0.25 -> -2.75
    tbl[1].x[31:0] = 32'hFFFE_0000;
    tbl[1].w[31:0] = 32'h0001_8000;
    tbl[1].b[31:0] = 32'h0000_4000;
    tbl[1].exp     = {32'h0000_0000, 32'hFFFD_4000};
    // Overflowing product keeps only the low word, no saturation
    tbl[2].x[31:0] = 32'h7FFF_0000;
    tbl[2].w[31:0] = 32'h7FFF_0000;
    tbl[2].exp     = {32'h0000_0000, 32'h0001_0000};
    // 1.0 * 1.0 summed nine times -> 9.0
    for (int i = 0; i < N; i++)   tbl[3].x[i*B +: B] = 32'h0001_0000;
    for (int i = 0; i < N*M; i++) tbl[3].w[i*B +: B] = 32'h0001_0000;
    tbl[3].exp = {32'h0009_0000, 32'h0009_0000};
    for (int t = 4; t < NVEC; t++) begin
      for (int i = 0; i < N; i++)   tbl[t].x[i*B +: B] = $urandom();
      for (int i = 0; i < N*M; i++) tbl[t].w[i*B +: B] = $urandom();
      for (int i = 0; i < M; i++)   tbl[t].b[i*B +: B] = $urandom();
      tbl[t].exp = model(tbl[t].x, tbl[t].w, tbl[t].b);
    end

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.x = '0; bus.w = '0; bus.b = '0; cur_exp = '0;
    #12;
    chk("rst_in_ready", (M*B)'(bus.in_ready), 1);
    chk("rst_out_valid", (M*B)'(bus.out_valid), 0);
    chk("rst_busy", (M*B)'(bus.busy), 0);
    chk("rst_out", bus.out, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    for (int t = 0; t < NVEC; t++) run_job(tbl[t], $sformatf("vec%0d", t));

    // Result held under backpressure; in_valid pulses must be ignored.
    bus.out_ready = 1'b0;
    wait_ready("bp_ready");
    start_job(tbl[1]);
    wait_out("bp_out_valid");
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = k[0];
      scramble();
      chk("bp_out_valid_hold", (M*B)'(bus.out_valid), 1);
      chk("bp_out_hold", bus.out, tbl[1].exp);
      chk("bp_in_ready_low", (M*B)'(bus.in_ready), 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_in_ready", (M*B)'(bus.in_ready), 1);
    chk("bp_release_out_valid", (M*B)'(bus.out_valid), 0);

    // Back-to-back with in_valid held: job B must start on the first IDLE cycle.
    wait_ready("b2b_ready");
    drive(tbl[4]);
    bus.in_valid = 1'b1;
    tick();
    drive(tbl[3]);
    wait_out("b2b_a_out_valid");
    chk("b2b_a_out", bus.out, tbl[4].exp);
    tick();
    chk("b2b_idle_in_ready", (M*B)'(bus.in_ready), 1);
    tick();
    chk("b2b_b_accepted", (M*B)'(bus.busy), 1);
    bus.in_valid = 1'b0;
    wait_out("b2b_b_out_valid");
    chk("b2b_b_out", bus.out, tbl[3].exp);
    tick();

    // Asynchronous reset seven cycles into a job aborts it.
    wait_ready("rst_mid_ready");
    start_job(tbl[0]);
    for (int k = 0; k < 6; k++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_in_ready", (M*B)'(bus.in_ready), 1);
    chk("rst_mid_out_valid", (M*B)'(bus.out_valid), 0);
    chk("rst_mid_busy", (M*B)'(bus.busy), 0);
    chk("rst_mid_out", bus.out, 0);
    sb_q.delete();
    in_flight = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    run_job(tbl[3], "post_rst");

    repeat (3) tick();
    chk("sb_empty", (M*B)'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
